// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: radix-2 shift-add multiply and restoring divide
// on magnitudes sharing one accumulator, sign correction applied in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             busy_q, done_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic             sgn_s, div_s, a_neg_s, b_neg_s, b_zero_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH+1:0] div_diff_s;
  logic [PW-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  // Decode and condition the operands presented with start
  always_comb begin
    sgn_s    = op_is_signed(op);
    div_s    = op_is_div(op);
    a_neg_s  = sgn_s & a[WIDTH-1];
    b_neg_s  = sgn_s & b[WIDTH-1];
    a_mag_s  = a_neg_s ? (~a + WIDTH'(1)) : a;
    b_mag_s  = b_neg_s ? (~b + WIDTH'(1)) : b;
    b_zero_s = (b == '0);
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !annul) begin
          if (div_s && b_zero_s) state_d = ST_FIX;
          else                   state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (annul)                    state_d = ST_IDLE;
        else if (cnt_q == LAST_ITER)  state_d = ST_FIX;
        else                          state_d = ST_CALC;
      end
      ST_FIX: begin
        if (annul) state_d = ST_IDLE;
        else       state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and status flags, registered from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Iteration step, sign fix-up and result capture
  always_comb begin
    // Upper accumulator bit is always zero for multiply, so the add never overflows
    mul_sum_s  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_diff_s = {1'b0, acc_q[AW-2:WIDTH-1]} - {2'b00, opnd_q};
    prod_s     = neg_lo_q ? (~acc_q[PW-1:0] + PW'(1)) : acc_q[PW-1:0];
    quo_s      = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_s      = neg_hi_q ? (~acc_q[PW-1:WIDTH] + WIDTH'(1)) : acc_q[PW-1:WIDTH];

    acc_d      = acc_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !annul) begin
          cnt_d    = '0;
          is_div_d = div_s;
          dz_d     = div_s & b_zero_s;
          neg_lo_d = a_neg_s ^ b_neg_s;
          neg_hi_d = a_neg_s;
          if (div_s) begin
            opnd_d = b_mag_s;
            // Divide-by-zero keeps the raw dividend so it can be returned in hi
            if (b_zero_s) acc_d = {{(WIDTH + 1){1'b0}}, a};
            else          acc_d = {{(WIDTH + 1){1'b0}}, a_mag_s};
          end else begin
            opnd_d = a_mag_s;
            acc_d  = {{(WIDTH + 1){1'b0}}, b_mag_s};
          end
        end else begin
          acc_d = acc_q;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          if (div_diff_s[WIDTH+1]) acc_d = {acc_q[AW-2:0], 1'b0};
          else                     acc_d = {div_diff_s[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {1'b0, mul_sum_s, acc_q[WIDTH-1:1]};
        end
      end
      ST_FIX: begin
        if (annul) begin
          hi_d = hi_q;
        end else if (dz_q) begin
          hi_d       = acc_q[WIDTH-1:0];
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          hi_d       = rem_s;
          lo_d       = quo_s;
          div_zero_d = 1'b0;
        end else begin
          hi_d       = prod_s[PW-1:WIDTH];
          lo_d       = prod_s[WIDTH-1:0];
          div_zero_d = 1'b0;
        end
      end
      ST_DONE: acc_d = acc_q;
      default: acc_d = acc_q;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width in bits (WIDTH >= 4, even).
REQ-002 The module SHALL have one clock and synchronous active-low reset, with ports listed in REQ-003..REQ-014.
REQ-003 clk  input  1  Sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  Synchronous reset, active-low, sampled on rising edge of clk.
REQ-005 start  input  1  Request a new operation; honoured only in IDLE.
REQ-006 op  input  2  Operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-007 annul  input  1  Abort the in-flight operation.
REQ-008 a  input  WIDTH  Multiplicand or dividend; sampled with start.
REQ-009 b  input  WIDTH  Multiplier or divisor; sampled with start.
REQ-010 hi  output  WIDTH  Product upper half, or remainder.
REQ-011 lo  output  WIDTH  Product lower half, or quotient.
REQ-012 busy  output  1  High in every state except IDLE.
REQ-013 done  output  1  One-cycle pulse; hi/lo/div_zero are valid from this cycle.
REQ-014 div_zero  output  1  Divisor was zero; valid with done, held until next accepted start.

Function
REQ-015 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-016 Transitions SHALL be as follows:
- IDLE -> CALC on start & ~annul.
- IDLE -> FIX on start & ~annul for DIV/DIVU with b == 0.
- CALC -> FIX after exactly WIDTH iterations.
- FIX -> DONE.
- DONE -> IDLE.
REQ-017 Accepting a start SHALL latch op, a and b internally; later input changes SHALL NOT affect the result.
REQ-018 For signed ops (MULT, DIV), operands SHALL be converted to magnitudes at start, and the result sign SHALL be applied in FIX.
REQ-019 Multiply SHALL be radix-2 shift-add, one bit per CALC cycle, producing the 2*WIDTH-bit product {hi, lo}.
REQ-020 Divide SHALL be restoring, one quotient bit per CALC cycle.
- The quotient sign SHALL be sign(a) XOR sign(b).
- The remainder sign SHALL follow a.
REQ-021 Latency: with start accepted in cycle 0, done SHALL be high in cycle WIDTH+2, and busy SHALL be high in cycles 1..WIDTH+2.
REQ-022 Divide-by-zero: done SHALL be high in cycle 2, with div_zero=1, hi=a and lo = all ones; no CALC cycles.
REQ-023 DIV of the most negative value by -1 SHALL give lo = most negative value (wrap) and hi = 0, with no flag.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 Annul:
- annul high in CALC or FIX SHALL force IDLE at the next edge, with no done pulse.
- hi, lo and div_zero SHALL keep their values from before the aborted op.
- annul in DONE SHALL be ignored.
REQ-026 start and annul together in IDLE: annul SHALL win and the start SHALL be dropped.
REQ-027 hi, lo and div_zero SHALL update only in the cycle done rises, and SHALL otherwise hold.
REQ-028 done SHALL never be high two consecutive cycles.

Reset
REQ-029 rst low SHALL force, at the next edge:
- state = IDLE;
- hi = 0, lo = 0;
- busy = 0, done = 0, div_zero = 0;
- internal accumulators cleared.
REQ-030 Reset during CALC or FIX SHALL abort the operation, with no done pulse, taking precedence over start and annul.

Structure
REQ-031 Package muldiv_pkg SHALL hold the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV) and the FSM state enumeration.
REQ-032 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and is local to the module.
REQ-033 Shift-add and restoring-divide datapaths SHALL share one 2*WIDTH+1-bit accumulator, with no sub-module.

Verification (WIDTH=32)
REQ-034 Multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, div_zero=0.
REQ-035 Signed multiply: MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 Signed divide and overflow case:
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Divide-by-zero: DIVU a=100, b=0 -> done in cycle 2, div_zero=1, hi=100, lo=0xFFFFFFFF.
REQ-038 Annul: after a completed op leaves hi=0x12345678, start MULTU, then annul in cycle 10 -> busy=0 from cycle 11, no done, hi still 0x12345678.
REQ-039 Mid-op events during a DIVU:
- start in cycle 5 is ignored, and the original result arrives in cycle 34.
- rst low in cycle 8 instead -> all outputs 0 from cycle 9, no done.
